// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: Gray read pointer, binary read address, empty flag,
// read handshake, sticky underflow and occupancy count (single clock domain).
module fifo_read_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en,
  input  logic [SIZE-1:0] w_pointer,
  output logic [SIZE-1:0] r_pointer,
  output logic [SIZE-2:0] r_addr,
  output logic            e_flag,
  output logic            rd_valid,
  output logic            underflow,
  output logic [SIZE-1:0] r_count
);

  logic [SIZE-1:0] r_bin;
  logic [SIZE-1:0] r_bin_next;
  logic [SIZE-1:0] w_bin;
  logic            accept;

  always_comb begin
    e_flag     = (w_pointer == r_pointer);
    accept     = rd_en && !e_flag;
    r_bin_next = accept ? r_bin + SIZE'(1) : r_bin;
  end

  // Gray-to-binary of the write pointer, MSB downwards.
  always_comb begin
    w_bin = '0;
    w_bin[SIZE-1] = w_pointer[SIZE-1];
    for (int unsigned i = SIZE - 1; i > 0; i--) begin
      w_bin[i-1] = w_bin[i] ^ w_pointer[i-1];
    end
  end

  assign r_count = w_bin - r_bin;
  assign r_addr  = r_bin[SIZE-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin     <= '0;
      r_pointer <= '0;
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      r_bin     <= r_bin_next;
      r_pointer <= r_bin_next ^ (r_bin_next >> 1);
      rd_valid  <= accept;
      if (rd_en && e_flag) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus randomized
// traffic compared against a read/write-count model.
module tb_fifo_read_ctrl;

  localparam int SIZE  = 4;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rd_en = 1'b0;
  logic [SIZE-1:0] w_pointer = '0;
  logic [SIZE-1:0] r_pointer;
  logic [SIZE-2:0] r_addr;
  logic            e_flag;
  logic            rd_valid;
  logic            underflow;
  logic [SIZE-1:0] r_count;

  int tests = 0;
  int fails = 0;

  // Model: total entries written/read (mod 2^SIZE), plus expected registered flags.
  int rcnt = 0;
  int wcnt = 0;
  bit exp_vld = 1'b0;
  bit exp_uf  = 1'b0;

  fifo_read_ctrl #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .w_pointer (w_pointer),
    .r_pointer (r_pointer),
    .r_addr    (r_addr),
    .e_flag    (e_flag),
    .rd_valid  (rd_valid),
    .underflow (underflow),
    .r_count   (r_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [SIZE-1:0] gray(input int v);
    logic [SIZE-1:0] b;
    b = SIZE'(v % MOD);
    return b ^ (b >> 1);
  endfunction

  function automatic int occ();
    return (wcnt + MOD - rcnt) % MOD;
  endfunction

  task automatic setw(input int n);
    wcnt      = n % MOD;
    w_pointer = gray(wcnt);
  endtask

  // One clock: predict accept/underflow from pre-edge state, land 1 time unit after the edge.
  task automatic tick();
    bit acc;
    acc = rd_en && (occ() != 0);
    if (rd_en && occ() == 0) exp_uf = 1'b1;
    @(posedge clk);
    if (acc) rcnt = (rcnt + 1) % MOD;
    exp_vld = acc;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    rcnt = 0;
    exp_vld = 1'b0;
    exp_uf = 1'b0;
  endtask

  task automatic test_reset();
    setw(0);
    #1;
    tests++; if (e_flag !== 1'b1) begin fails++; $display("FAIL reset_e_flag: got %b expected 1", e_flag); end
    tests++; if (r_pointer !== 4'b0000) begin fails++; $display("FAIL reset_r_pointer: got %b expected 0000", r_pointer); end
    tests++; if (r_addr !== 3'd0) begin fails++; $display("FAIL reset_r_addr: got %0d expected 0", r_addr); end
    tests++; if (r_count !== 4'd0) begin fails++; $display("FAIL reset_r_count: got %0d expected 0", r_count); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sequential_read();
    logic [SIZE-1:0] exp_ptr [3] = '{4'b0001, 4'b0011, 4'b0010};
    setw(3);
    rd_en = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (r_count !== 4'(3 - i)) begin fails++; $display("FAIL seq_r_count[%0d]: got %0d expected %0d", i, r_count, 3 - i); end
      tick();
      tests++; if (r_pointer !== exp_ptr[i]) begin fails++; $display("FAIL seq_r_pointer[%0d]: got %b expected %b", i, r_pointer, exp_ptr[i]); end
      tests++; if (r_addr !== 3'(i + 1)) begin fails++; $display("FAIL seq_r_addr[%0d]: got %0d expected %0d", i, r_addr, i + 1); end
      tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL seq_rd_valid[%0d]: got %b expected 1", i, rd_valid); end
    end
    rd_en = 1'b0;
    tests++; if (e_flag !== 1'b1) begin fails++; $display("FAIL seq_e_flag: got %b expected 1", e_flag); end
    tests++; if (r_count !== 4'd0) begin fails++; $display("FAIL seq_r_count_end: got %0d expected 0", r_count); end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL seq_rd_valid_drop: got %b expected 0", rd_valid); end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (r_pointer !== 4'b0010) begin fails++; $display("FAIL uf_r_pointer: got %b expected 0010", r_pointer); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL uf_rd_valid: got %b expected 0", rd_valid); end
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_set: got %b expected 1", underflow); end
    setw(4);
    tick();
    tick();
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky: got %b expected 1", underflow); end
    do_reset();
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL uf_cleared: got %b expected 0", underflow); end
  endtask

  task automatic test_full();
    do_reset();
    setw(8);
    #1;
    tests++; if (w_pointer !== 4'b1100) begin fails++; $display("FAIL full_setup: got %b expected 1100", w_pointer); end
    tests++; if (e_flag !== 1'b0) begin fails++; $display("FAIL full_e_flag: got %b expected 0", e_flag); end
    tests++; if (r_count !== 4'd8) begin fails++; $display("FAIL full_r_count: got %0d expected 8", r_count); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (r_pointer !== 4'b0001) begin fails++; $display("FAIL full_r_pointer: got %b expected 0001", r_pointer); end
    tests++; if (r_count !== 4'd7) begin fails++; $display("FAIL full_r_count_after: got %0d expected 7", r_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    setw(7);
    rd_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rd_en = 1'b0;
    setw(9);
    #1;
    tests++; if (r_pointer !== 4'b0100) begin fails++; $display("FAIL wrap_r_pointer7: got %b expected 0100", r_pointer); end
    tests++; if (r_count !== 4'd2) begin fails++; $display("FAIL wrap_r_count2: got %0d expected 2", r_count); end
    rd_en = 1'b1;
    tick();
    tests++; if (r_pointer !== 4'b1100) begin fails++; $display("FAIL wrap_r_pointer8: got %b expected 1100", r_pointer); end
    tests++; if (r_addr !== 3'd0) begin fails++; $display("FAIL wrap_r_addr8: got %0d expected 0", r_addr); end
    tests++; if (r_count !== 4'd1) begin fails++; $display("FAIL wrap_r_count1: got %0d expected 1", r_count); end
    tick();
    tests++; if (r_pointer !== 4'b1101) begin fails++; $display("FAIL wrap_r_pointer9: got %b expected 1101", r_pointer); end
    tests++; if (e_flag !== 1'b1) begin fails++; $display("FAIL wrap_e_flag9: got %b expected 1", e_flag); end
    setw(15);
    for (int i = 0; i < 6; i++) tick();
    tests++; if (r_pointer !== 4'b1000) begin fails++; $display("FAIL wrap_r_pointer15: got %b expected 1000", r_pointer); end
    setw(16);
    #1;
    tests++; if (r_count !== 4'd1) begin fails++; $display("FAIL wrap_r_count_w0: got %0d expected 1", r_count); end
    tick();
    rd_en = 1'b0;
    tests++; if (r_pointer !== 4'b0000) begin fails++; $display("FAIL wrap_r_pointer0: got %b expected 0000", r_pointer); end
    tests++; if (e_flag !== 1'b1) begin fails++; $display("FAIL wrap_e_flag0: got %b expected 1", e_flag); end
  endtask

  task automatic test_async_reset();
    do_reset();
    setw(5);
    rd_en = 1'b1;
    tick();
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid: got %b expected 1", rd_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (r_pointer !== 4'b0000) begin fails++; $display("FAIL arst_r_pointer: got %b expected 0000", r_pointer); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL arst_rd_valid: got %b expected 0", rd_valid); end
    tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL arst_underflow: got %b expected 0", underflow); end
    rst = 1'b0;
    rcnt = 0;
    exp_vld = 1'b0;
    exp_uf = 1'b0;
    #1;
    tests++; if (r_addr !== 3'd0) begin fails++; $display("FAIL arst_r_addr: got %0d expected 0", r_addr); end
    tick();
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL arst_first_valid: got %b expected 1", rd_valid); end
    tests++; if (r_pointer !== 4'b0001) begin fails++; $display("FAIL arst_first_ptr: got %b expected 0001", r_pointer); end
  endtask

  task automatic test_random();
    do_reset();
    setw(0);
    for (int n = 0; n < 400; n++) begin
      rd_en = ($urandom_range(0, 3) != 0);
      if (occ() < DEPTH && $urandom_range(0, 1) == 1) setw(wcnt + 1);
      #1;
      tests++; if (e_flag !== (occ() == 0)) begin fails++; $display("FAIL rnd_e_flag@%0d: got %b expected %b", n, e_flag, occ() == 0); end
      tests++; if (r_count !== 4'(occ())) begin fails++; $display("FAIL rnd_r_count@%0d: got %0d expected %0d", n, r_count, occ()); end
      tests++; if (r_addr !== 3'(rcnt % DEPTH)) begin fails++; $display("FAIL rnd_r_addr@%0d: got %0d expected %0d", n, r_addr, rcnt % DEPTH); end
      tick();
      tests++; if (r_pointer !== gray(rcnt)) begin fails++; $display("FAIL rnd_r_pointer@%0d: got %b expected %b", n, r_pointer, gray(rcnt)); end
      tests++; if (rd_valid !== exp_vld) begin fails++; $display("FAIL rnd_rd_valid@%0d: got %b expected %b", n, rd_valid, exp_vld); end
      tests++; if (underflow !== exp_uf) begin fails++; $display("FAIL rnd_underflow@%0d: got %b expected %b", n, underflow, exp_uf); end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential_read();
    test_underflow();
    test_full();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
